// File: rtl/cs_mult_sequencer.sv
// cs_mult_sequencer: one WIDTH x WIDTH unsigned multiply.
// A single 4x4 carry-save array is stepped over every 4-bit digit pair of the
// latched operands. Each shifted 8-bit partial product is added into a
// 2*WIDTH-bit accumulator. This costs latency but saves area compared with a
// full-width array.

// multiCS4_fullbasecell: combinational 4x4 unsigned carry-save array multiplier.
// Rows of full adders keep sums and carries apart. A final 4-bit ripple adder
// merges the last row into the upper product nibble.
module multiCS4_fullbasecell (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  output logic [7:0] o_p
);
  logic [3:0][3:0] w_pp;   // w_pp[r][c] = a[c] & b[r], weight r+c
  logic [3:0][3:0] w_s;    // row sums, weight r+c
  logic [3:0][3:0] w_c;    // row carries, weight r+c+1
  logic [3:0]      w_x;    // final merge operand (row-3 sums, weights 4..7)
  logic [3:0]      w_rc;   // ripple carries of the final merge

  for (genvar r = 0; r < 4; r++) begin : g_row
    for (genvar c = 0; c < 4; c++) begin : g_col
      assign w_pp[r][c] = i_a[c] & i_b[r];
      if (r == 0) begin : g_first
        assign w_s[r][c] = w_pp[r][c];
        assign w_c[r][c] = 1'b0;
      end else begin : g_fa
        // The sum from the row above is taken one column to the right, which
        // gives the same weight. The leftmost column has no such sum.
        logic w_sin;
        if (c == 3) begin : g_edge
          assign w_sin = 1'b0;
        end else begin : g_inner
          assign w_sin = w_s[r-1][c+1];
        end
        assign w_s[r][c] = w_pp[r][c] ^ w_sin ^ w_c[r-1][c];
        assign w_c[r][c] = (w_pp[r][c] & w_sin) | (w_pp[r][c] & w_c[r-1][c]) |
                           (w_sin & w_c[r-1][c]);
      end
    end
  end

  // Low nibble comes straight out of column 0 of each row.
  assign o_p[3:0] = {w_s[3][0], w_s[2][0], w_s[1][0], w_s[0][0]};
  assign w_x      = {1'b0, w_s[3][3:1]};
  assign w_rc[0]  = 1'b0;

  // Final merge. The product is at most 225, so the top carry never leaves bit 7.
  for (genvar k = 0; k < 4; k++) begin : g_merge
    assign o_p[4+k] = w_x[k] ^ w_c[3][k] ^ w_rc[k];
    if (k < 3) begin : g_cy
      assign w_rc[k+1] = (w_x[k] & w_c[3][k]) | (w_x[k] & w_rc[k]) |
                         (w_c[3][k] & w_rc[k]);
    end
  end
endmodule

module cs_mult_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [WIDTH-1:0]     factor1_i,
  input  logic [WIDTH-1:0]     factor2_i,
  output logic                 res_valid_o,
  input  logic                 res_ready_i,
  output logic [2*WIDTH-1:0]   product_o,
  output logic                 busy_o
);
  localparam int DIGITS = WIDTH / 4;
  localparam int PW     = 2 * WIDTH;
  localparam int CW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

  if ((WIDTH % 4) != 0 || WIDTH < 8) begin : g_bad_width
    $error("cs_mult_sequencer: WIDTH must be a multiple of 4 and >= 8");
  end

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t          r_state;
  logic [WIDTH-1:0] r_fa;
  logic [WIDTH-1:0] r_fb;
  logic [PW-1:0]   r_acc;
  logic [CW-1:0]   r_i;
  logic [CW-1:0]   r_j;

  logic [3:0]      w_a;
  logic [3:0]      w_b;
  logic [7:0]      w_pp8;
  logic [CW:0]     w_shamt;    // digit position i+j; shift is 4x this
  logic [PW-1:0]   w_pp_sh;
  logic [PW-1:0]   w_sum;
  logic            w_accept;

  // Select the current digit pair from the latched operands.
  assign w_a = r_fa[{r_i, 2'b00} +: 4];
  assign w_b = r_fb[{r_j, 2'b00} +: 4];

  multiCS4_fullbasecell u_cell (
    .i_a (w_a),
    .i_b (w_b),
    .o_p (w_pp8)
  );

  // Zero-extend the partial product, move it to weight 4*(i+j), and add it in.
  // The true product fits in PW bits, so the add cannot overflow.
  assign w_shamt  = {1'b0, r_i} + {1'b0, r_j};
  assign w_pp_sh  = {{(PW-8){1'b0}}, w_pp8} << {w_shamt, 2'b00};
  assign w_sum    = r_acc + w_pp_sh;
  assign w_accept = req_valid_i & req_ready_o;

  // Sequencer FSM. All handshake outputs are registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      req_ready_o <= 1'b1;
      res_valid_o <= 1'b0;
      busy_o      <= 1'b0;
      product_o   <= '0;
      r_fa        <= '0;
      r_fb        <= '0;
      r_acc       <= '0;
      r_i         <= '0;
      r_j         <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_fa        <= factor1_i;
            r_fb        <= factor2_i;
            r_acc       <= '0;
            r_i         <= '0;
            r_j         <= '0;
            r_state     <= S_CALC;
            req_ready_o <= 1'b0;
            busy_o      <= 1'b1;
          end
        end
        S_CALC: begin
          r_acc <= w_sum;
          if (r_j == LAST) begin
            r_j <= '0;
            if (r_i == LAST) begin
              // Last digit pair: w_sum is the complete product.
              product_o   <= w_sum;
              res_valid_o <= 1'b1;
              r_state     <= S_DONE;
            end else begin
              r_i <= r_i + 1'b1;
            end
          end else begin
            r_j <= r_j + 1'b1;
          end
        end
        S_DONE: begin
          // Hold the result until it is consumed. A new request is only seen
          // again from IDLE.
          if (res_ready_i) begin
            res_valid_o <= 1'b0;
            busy_o      <= 1'b0;
            req_ready_o <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          req_ready_o <= 1'b1;
          res_valid_o <= 1'b0;
          busy_o      <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_cs_mult_sequencer.sv
// Directed bench for cs_mult_sequencer at WIDTH=8 and WIDTH=16.
module tb_cs_mult_sequencer;
  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst8, rv8, rr8, vv8, rdy8, busy8;
  logic [7:0]  f1_8, f2_8;
  logic [15:0] p8;
  logic        rst16, rv16, rr16, vv16, rdy16, busy16;
  logic [15:0] f1_16, f2_16;
  logic [31:0] p16;

  int n_chk = 0;
  int n_err = 0;

  cs_mult_sequencer #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst8), .req_valid_i(rv8), .req_ready_o(rr8),
    .factor1_i(f1_8), .factor2_i(f2_8), .res_valid_o(vv8),
    .res_ready_i(rdy8), .product_o(p8), .busy_o(busy8)
  );

  cs_mult_sequencer #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst16), .req_valid_i(rv16), .req_ready_o(rr16),
    .factor1_i(f1_16), .factor2_i(f2_16), .res_valid_o(vv16),
    .res_ready_i(rdy16), .product_o(p16), .busy_o(busy16)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request and wait for the result. exp_lat=0 skips the latency check.
  task automatic run_op(input bit w16, input logic [15:0] a, input logic [15:0] b,
                        input logic [31:0] exp, input int exp_lat, input bit scr,
                        input string tag);
    int n;
    logic v;
    @(negedge clk);
    if (w16) begin f1_16 = a; f2_16 = b; rv16 = 1'b1; end
    else     begin f1_8 = a[7:0]; f2_8 = b[7:0]; rv8 = 1'b1; end
    chk({tag, " ready"}, {31'h0, w16 ? rr16 : rr8}, 32'h1);
    @(posedge clk); #1;
    rv8 = 1'b0; rv16 = 1'b0;
    n = 0; v = 1'b0;
    while (!v && n < 60) begin
      if (scr) begin f1_8 = 8'($urandom); f2_8 = 8'($urandom); end
      @(posedge clk); n++;
      @(negedge clk);
      v = w16 ? vv16 : vv8;
    end
    if (exp_lat > 0) chk({tag, " lat"}, 32'(n), 32'(exp_lat));
    else if (!v) chk({tag, " timeout"}, 32'(n), 32'd0);
    chk({tag, " prod"}, w16 ? p16 : {16'h0, p8}, exp);
    if (w16 ? rdy16 : rdy8) begin
      @(posedge clk); @(negedge clk);
      chk({tag, " pulse"}, {31'h0, w16 ? vv16 : vv8}, 32'h0);
    end
  endtask

  initial begin
    int acc_e[$];
    logic [15:0] ra, rb;
    rst8 = 1'b1; rst16 = 1'b1; rv8 = 1'b0; rv16 = 1'b0;
    rdy8 = 1'b1; rdy16 = 1'b1;
    f1_8 = '0; f2_8 = '0; f1_16 = '0; f2_16 = '0;
    repeat (3) @(posedge clk);
    #1 rst8 = 1'b0; rst16 = 1'b0;
    @(negedge clk);
    chk("rst ready", {31'h0, rr8}, 32'h1);
    chk("rst valid", {31'h0, vv8}, 32'h0);
    chk("rst busy",  {31'h0, busy8}, 32'h0);
    chk("rst prod",  {16'h0, p8}, 32'h0);
    chk("rst16 prod", p16, 32'h0);

    // Basic products and corner operands
    run_op(1'b0, 16'h12, 16'h34, 32'h03A8, 4, 1'b0, "t1");
    run_op(1'b0, 16'hFF, 16'hFF, 32'hFE01, 4, 1'b0, "ffxff");
    run_op(1'b0, 16'h00, 16'hAB, 32'h0000, 4, 1'b0, "zero");

    // Back-to-back requests with valid held: accepts are six edges apart
    @(negedge clk);
    f1_8 = 8'h03; f2_8 = 8'h05; rv8 = 1'b1;
    for (int e = 0; e < 14; e++) begin
      if (rr8 && rv8) acc_e.push_back(e);
      @(posedge clk); @(negedge clk);
    end
    rv8 = 1'b0;
    if (acc_e.size() >= 2) chk("b2b spacing", 32'(acc_e[1] - acc_e[0]), 32'd6);
    else chk("b2b accepts", 32'(acc_e.size()), 32'd2);
    for (int k = 0; k < 30 && !(rr8 && !busy8); k++) @(negedge clk);
    chk("b2b idle", {31'h0, rr8}, 32'h1);
    chk("b2b prod", {16'h0, p8}, 32'h000F);

    // Backpressure: the result is held and new requests are ignored
    rdy8 = 1'b0;
    run_op(1'b0, 16'hA5, 16'h3C, 32'h26AC, 4, 1'b0, "bp");
    f1_8 = 8'h11; f2_8 = 8'h22; rv8 = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); @(negedge clk);
      chk("bp valid", {31'h0, vv8}, 32'h1);
      chk("bp ready", {31'h0, rr8}, 32'h0);
      chk("bp prod",  {16'h0, p8}, 32'h26AC);
    end
    rv8 = 1'b0; rdy8 = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("bp release", {30'h0, vv8, rr8}, 32'h1);

    // Operands change every cycle after the accept
    run_op(1'b0, 16'h9C, 16'h7B, 32'h4AF4, 4, 1'b1, "scramble");

    // Reset in the second CALC cycle aborts the operation
    @(negedge clk);
    f1_8 = 8'h55; f2_8 = 8'h66; rv8 = 1'b1;
    @(posedge clk); #1 rv8 = 1'b0;
    @(posedge clk); #1 rst8 = 1'b1;
    @(posedge clk); #1 rst8 = 1'b0;
    @(negedge clk);
    chk("abort ready", {31'h0, rr8}, 32'h1);
    chk("abort valid", {31'h0, vv8}, 32'h0);
    chk("abort busy",  {31'h0, busy8}, 32'h0);
    chk("abort prod",  {16'h0, p8}, 32'h0);
    run_op(1'b0, 16'h0F, 16'h0F, 32'h00E1, 4, 1'b0, "post rst");

    // WIDTH=16
    run_op(1'b1, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 16, 1'b0, "w16 max");
    run_op(1'b1, 16'h1234, 16'h5678, 32'h06260060, 16, 1'b0, "w16 mix");
    for (int k = 0; k < 1000; k++) begin
      ra = 16'($urandom_range(0, 65535));
      rb = 16'($urandom_range(0, 65535));
      run_op(1'b1, ra, rb, 32'(ra) * 32'(rb), 0, 1'b0, "w16 rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
